stat_event_counters: RTL and testbench
======================================

Name: stat_event_counters

Overview:
- Parametrised bank of per-event performance counters for the RISC-V core's statistic pulses (branch types, jal/jalr, pipeline flush, and similar), plus one free-running cycle counter.
- Sits beside the CPU at top level: stat_* outputs feed the evt bus, and a debug/testbench master reads counts through a registered read port.
- Adds what the current top level lacks: accumulation, wrap/saturate mode, rising-edge or level counting, atomic snapshot, and sticky overflow flags.

Parameters:
- N_EVT, 9, number of event channels (indices 0..N_EVT-1); cycle counter lives at index N_EVT.
- CNT_W, 32, width of every counter, snapshot register and rd_data.
- SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters stick at all-ones.
- EDGE_MODE, 0, 0 = count every cycle evt[i] is high; 1 = count only 0->1 transitions of evt[i].
- ADDR_W, 4, read address width; must satisfy 2^ADDR_W >= N_EVT+1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- evt  input  N_EVT  event strobes, bit i = channel i.
- en  input  1  count enable; 0 freezes all event counters and the cycle counter.
- clr  input  1  synchronous clear of all counters and overflow flags.
- snap  input  1  copy all live counters into the snapshot bank this cycle.
- rd_en  input  1  read request.
- rd_addr  input  ADDR_W  counter index to read.
- rd_snap  input  1  1 = read snapshot bank, 0 = read live counters.
- rd_data  output  CNT_W  read result.
- rd_valid  output  1  rd_data valid.
- ovf  output  N_EVT+1  sticky overflow flag per counter (bit N_EVT = cycle counter).

Behaviour:
- Reset (async, rst=1): all counters, snapshots, ovf, rd_data, rd_valid and edge-detect history registers = 0.
- Per cycle with en=1 and clr=0:
  - Channel i increments by 1 when its qualifier is true: evt[i] (EDGE_MODE=0), or evt[i] & ~evt_d[i] (EDGE_MODE=1).
  - Cycle counter increments unconditionally.
- evt_d updates every cycle regardless of en/clr, so the edge history stays correct across freeze.
- Overflow, counter at 2^CNT_W-1 with an increment due:
  - SATURATE=0: counter wraps to 0.
  - SATURATE=1: counter holds at all-ones.
  - In both modes ovf[i] sets and stays set until clr or rst.
- clr=1: all counters and ovf are 0 next cycle. clr wins over a simultaneous increment. Snapshot bank is not cleared.
- snap=1: snapshot[k] <= live counter k value before this edge's update, so snap and clr together capture the pre-clear values.
- Read: rd_en sampled at cycle T; rd_valid=1 and rd_data valid at T+1 (1-cycle latency).
  - rd_data reflects the source value as registered at edge T, i.e. before any update at that same edge.
  - rd_addr > N_EVT: rd_data=0, rd_valid=1.
  - rd_en=0: rd_valid=0 and rd_data holds its last value.
- Back-to-back reads every cycle are supported; no stalls.
- Reset mid-read: rd_valid drops immediately.
- No state machine beyond per-channel counters and the read-port register. Expected RTL size 150-250 lines.

Test Plan:
- Reset, then en=1 for 10 cycles with evt=0, read addr N_EVT (9) -> rd_valid one cycle later, rd_data=10; channels 0..8 read 0; ovf=0.
- EDGE_MODE=0: evt[0] high 5 cycles, low 3, high 2 -> ch0=7. EDGE_MODE=1, same stimulus -> ch0=2.
- CNT_W=4, SATURATE=0: 17 pulses on evt[3] -> ch3=1, ovf[3]=1. SATURATE=1, same stimulus -> ch3=15, ovf[3]=1.
- Count ch2 to 6, then assert snap and clr in the same cycle with evt[2]=1 -> snapshot ch2=6, live ch2=0 next cycle, ovf cleared. Read with rd_snap=1 -> 6.
- en=0 for 4 cycles while evt[1]=1 -> ch1 and cycle counter unchanged. With EDGE_MODE=1, evt[1] held high across en 0->1 -> no spurious count.
- rd_addr=15 -> rd_data=0, rd_valid=1. Assert rst mid-read -> rd_valid and all counters 0 asynchronously.

Source files
------------

// File: rtl/stat_event_counters_if.sv
// Read-port bundle for stat_event_counters: request side (master) and
// registered response side (slave).
interface stat_event_counters_if #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 4
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_snap;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_valid;

    modport master (output rd_en, rd_addr, rd_snap, input rd_data, rd_valid);
    modport slave  (input rd_en, rd_addr, rd_snap, output rd_data, rd_valid);
endinterface

// File: rtl/stat_event_counters.sv
// Bank of per-event performance counters plus a free-running cycle counter,
// with wrap/saturate, level/edge qualification, snapshot and sticky overflow.
module stat_event_counters #(
    parameter int N_EVT     = 9,
    parameter int CNT_W     = 32,
    parameter int SATURATE  = 0,
    parameter int EDGE_MODE = 0,
    parameter int ADDR_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_EVT-1:0]     evt,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 snap,
    stat_event_counters_if.slave rd,
    output logic [N_EVT:0]       ovf
);
    localparam int N_CNT = N_EVT + 1;

    logic [CNT_W-1:0] cnt       [N_CNT];
    logic [CNT_W-1:0] snap_bank [N_CNT];
    logic [N_EVT-1:0] evt_d;
    logic [N_EVT:0]   inc;
    logic [CNT_W-1:0] rd_src;

    // Cycle counter sits at index N_EVT and always has an increment due.
    assign inc = {1'b1, (EDGE_MODE != 0) ? (evt & ~evt_d) : evt};

    // Edge history follows evt even while frozen or clearing, so re-enabling
    // with an event already high never produces a spurious edge.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_d <= '0;
        end else begin
            evt_d <= evt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CNT; k++) begin
                cnt[k] <= '0;
            end
            ovf <= '0;
        end else if (clr) begin
            for (int k = 0; k < N_CNT; k++) begin
                cnt[k] <= '0;
            end
            ovf <= '0;
        end else if (en) begin
            for (int k = 0; k < N_CNT; k++) begin
                if (inc[k]) begin
                    if (&cnt[k]) begin
                        ovf[k] <= 1'b1;
                        if (SATURATE == 0) begin
                            cnt[k] <= '0;
                        end
                    end else begin
                        cnt[k] <= cnt[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Snapshot captures pre-update live values, so snap with clr keeps the
    // counts that the clear is about to discard.
    // NOTE: the banks are flop arrays rather than RAM, so they take the async
    // reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CNT; k++) begin
                snap_bank[k] <= '0;
            end
        end else if (snap) begin
            for (int k = 0; k < N_CNT; k++) begin
                snap_bank[k] <= cnt[k];
            end
        end
    end

    // Decoded compare rather than direct indexing: addresses past N_EVT read 0.
    // NOTE: rd_src is defaulted first so no path through the block leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_src = '0;
        for (int k = 0; k < N_CNT; k++) begin
            if (rd.rd_addr == ADDR_W'(k)) begin
                rd_src = rd.rd_snap ? snap_bank[k] : cnt[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
        end else begin
            rd.rd_valid <= rd.rd_en;
            if (rd.rd_en) begin
                rd.rd_data <= rd_src;
            end
        end
    end
endmodule

// File: tb/tb_stat_event_counters.sv
// Scoreboard bench: four configurations share one event stimulus; reads push
// expected values into per-instance queues that a negedge monitor drains.
module tb_stat_event_counters;
    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] evt;
    logic       en, clr, snap;
    logic [9:0] ovf0, ovf1, ovf2, ovf3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];

    stat_event_counters_if #(.CNT_W(32), .ADDR_W(4)) if0 ();
    stat_event_counters_if #(.CNT_W(32), .ADDR_W(4)) if1 ();
    stat_event_counters_if #(.CNT_W(4),  .ADDR_W(4)) if2 ();
    stat_event_counters_if #(.CNT_W(4),  .ADDR_W(4)) if3 ();

    // d0: level/wrap 32b, d1: edge 32b, d2: 4b wrap, d3: 4b saturate
    stat_event_counters #(.N_EVT(9), .CNT_W(32), .SATURATE(0), .EDGE_MODE(0), .ADDR_W(4)) d0 (
        .clk(clk), .rst(rst), .evt(evt), .en(en), .clr(clr), .snap(snap), .rd(if0), .ovf(ovf0));
    stat_event_counters #(.N_EVT(9), .CNT_W(32), .SATURATE(0), .EDGE_MODE(1), .ADDR_W(4)) d1 (
        .clk(clk), .rst(rst), .evt(evt), .en(en), .clr(clr), .snap(snap), .rd(if1), .ovf(ovf1));
    stat_event_counters #(.N_EVT(9), .CNT_W(4), .SATURATE(0), .EDGE_MODE(0), .ADDR_W(4)) d2 (
        .clk(clk), .rst(rst), .evt(evt), .en(en), .clr(clr), .snap(snap), .rd(if2), .ovf(ovf2));
    stat_event_counters #(.N_EVT(9), .CNT_W(4), .SATURATE(1), .EDGE_MODE(0), .ADDR_W(4)) d3 (
        .clk(clk), .rst(rst), .evt(evt), .en(en), .clr(clr), .snap(snap), .rd(if3), .ovf(ovf3));

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", n, act, exp);
    endtask

    task automatic unexpected(input string n);
        total_cnt++;
        $display("FAIL %s: rd_valid with no read outstanding", n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_end();
        if0.rd_en = 1'b0;
        if1.rd_en = 1'b0;
        if2.rd_en = 1'b0;
        if3.rd_en = 1'b0;
    endtask

    // Issue one read on instance inst for one edge; reads may be chained.
    task automatic rd(input int inst, input int addr, input logic s,
                      input logic [31:0] e, input string n);
        exp_t x;
        x.name = n;
        x.exp  = e;
        rd_end();
        case (inst)
            0: begin if0.rd_en = 1'b1; if0.rd_addr = 4'(addr); if0.rd_snap = s; q0.push_back(x); end
            1: begin if1.rd_en = 1'b1; if1.rd_addr = 4'(addr); if1.rd_snap = s; q1.push_back(x); end
            2: begin if2.rd_en = 1'b1; if2.rd_addr = 4'(addr); if2.rd_snap = s; q2.push_back(x); end
            default: begin if3.rd_en = 1'b1; if3.rd_addr = 4'(addr); if3.rd_snap = s; q3.push_back(x); end
        endcase
        step();
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (if0.rd_valid) begin
            if (q0.size() == 0) unexpected("d0");
            else begin x = q0.pop_front(); check(x.name, if0.rd_data, x.exp); end
        end
        if (if1.rd_valid) begin
            if (q1.size() == 0) unexpected("d1");
            else begin x = q1.pop_front(); check(x.name, if1.rd_data, x.exp); end
        end
        if (if2.rd_valid) begin
            if (q2.size() == 0) unexpected("d2");
            else begin x = q2.pop_front(); check(x.name, 32'(if2.rd_data), x.exp); end
        end
        if (if3.rd_valid) begin
            if (q3.size() == 0) unexpected("d3");
            else begin x = q3.pop_front(); check(x.name, 32'(if3.rd_data), x.exp); end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; evt = '0; en = 1'b0; clr = 1'b0; snap = 1'b0;
        rd_end();
        if0.rd_addr = '0; if0.rd_snap = 1'b0;
        if1.rd_addr = '0; if1.rd_snap = 1'b0;
        if2.rd_addr = '0; if2.rd_snap = 1'b0;
        if3.rd_addr = '0; if3.rd_snap = 1'b0;
        step(); step();
        check("rst_rd_valid", 32'(if0.rd_valid), 0);
        check("rst_rd_data", if0.rd_data, 0);
        check("rst_ovf_d0", 32'(ovf0), 0);
        rst = 1'b0;

        // Idle counting: cycle counter only
        en = 1'b1;
        repeat (10) step();
        en = 1'b0;
        rd(0, 9, 1'b0, 10, "d0_cyc_idle");
        for (int k = 0; k < 9; k++) rd(0, k, 1'b0, 0, $sformatf("d0_ch%0d_idle", k));
        rd_end();
        check("d0_ovf_idle", 32'(ovf0), 0);

        // Level vs edge: high 5, low 3, high 2
        en = 1'b1;
        evt[0] = 1'b1; repeat (5) step();
        evt[0] = 1'b0; repeat (3) step();
        evt[0] = 1'b1; repeat (2) step();
        evt = '0; en = 1'b0;
        rd(0, 0, 1'b0, 7, "d0_ch0_level");
        rd(1, 0, 1'b0, 2, "d1_ch0_edge");
        rd(0, 9, 1'b0, 20, "d0_cyc_after_ch0");
        rd_end();

        // 17 cycles of evt[3] on 4-bit counters
        en = 1'b1;
        evt[3] = 1'b1; repeat (17) step();
        evt = '0; en = 1'b0;
        rd(2, 3, 1'b0, 1, "d2_ch3_wrap");
        rd(3, 3, 1'b0, 15, "d3_ch3_sat");
        rd(0, 3, 1'b0, 17, "d0_ch3_17");
        rd(1, 3, 1'b0, 1, "d1_ch3_edge_held");
        rd_end();
        check("d2_ovf3", 32'(ovf2[3]), 1);
        check("d3_ovf3", 32'(ovf3[3]), 1);
        check("d0_ovf_none", 32'(ovf0), 0);

        // Snapshot and clear together, with an increment pending on ch2
        en = 1'b1;
        evt[2] = 1'b1; repeat (6) step();
        snap = 1'b1; clr = 1'b1;
        step();
        snap = 1'b0; clr = 1'b0; en = 1'b0; evt = '0;
        check("d2_ovf_cleared", 32'(ovf2), 0);
        check("d3_ovf_cleared", 32'(ovf3), 0);
        rd(0, 2, 1'b0, 0, "d0_ch2_live_cleared");
        rd(0, 2, 1'b1, 6, "d0_ch2_snap");
        rd(0, 9, 1'b1, 43, "d0_cyc_snap");
        rd(0, 9, 1'b0, 0, "d0_cyc_live_cleared");
        rd(3, 3, 1'b1, 15, "d3_ch3_snap");
        rd_end();

        // Freeze with evt[1] held high, then resume
        en = 1'b1;
        evt[1] = 1'b1; repeat (3) step();
        en = 1'b0;
        repeat (4) step();
        rd(0, 1, 1'b0, 3, "d0_ch1_frozen");
        rd(0, 9, 1'b0, 3, "d0_cyc_frozen");
        rd(1, 1, 1'b0, 1, "d1_ch1_frozen");
        rd_end();
        en = 1'b1;
        repeat (2) step();
        en = 1'b0; evt = '0;
        rd(0, 1, 1'b0, 5, "d0_ch1_resumed");
        rd(0, 9, 1'b0, 5, "d0_cyc_resumed");
        rd(1, 1, 1'b0, 1, "d1_ch1_no_spurious");
        rd(1, 9, 1'b0, 5, "d1_cyc_resumed");
        rd_end();
        step(); step();
        check("d1_rd_valid_idle", 32'(if1.rd_valid), 0);
        check("d1_rd_data_hold", if1.rd_data, 5);

        // Out-of-range address, then reset while a response is presented
        rd(0, 15, 1'b0, 0, "d0_addr15");
        rd_end();
        step();
        rd(0, 9, 1'b0, 5, "d0_cyc_pre_rst");
        rd_end();
        check("pre_rst_valid", 32'(if0.rd_valid), 1);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(if0.rd_valid), 0);
        check("rst_async_data", if0.rd_data, 0);
        q0.delete();
        step();
        rst = 1'b0;
        check("post_rst_ovf_d3", 32'(ovf3), 0);
        rd(0, 9, 1'b0, 0, "d0_cyc_post_rst");
        rd(0, 2, 1'b1, 0, "d0_snap_post_rst");
        rd(3, 3, 1'b1, 0, "d3_snap_post_rst");
        rd(1, 1, 1'b0, 0, "d1_ch1_post_rst");
        rd_end();

        repeat (3) step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        check("q3_drained", q3.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
